// File: rtl/vpu_stream_pkg.sv
// vpu_stream_pkg: shared types and constants for the streaming vector
// post-processor (vpu_stream) and its per-lane datapath (vpu_lane).
//   vpu_state_e  : tile-level controller states
//   MODE_*       : bit positions inside the 4-bit mode word
package vpu_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_BIAS,
    STREAM,
    DRAIN,
    DONE
  } vpu_state_e;

  localparam int MODE_BIAS_EN = 0;
  localparam int MODE_ACT_EN  = 1;
  localparam int MODE_LEAKY   = 2;

endpackage

// File: rtl/vpu_lane.sv
// vpu_lane: two-stage arithmetic for one lane of vpu_stream.
//   S1: t = x + (bias_en ? b : 0), kept at DATA_W+1 bits so the sum never wraps.
//   S2: ReLU / leaky-ReLU on t, then narrowing back to DATA_W bits
//       (clamp when VPU_STREAM_SAT_EN is defined, two's-complement wrap otherwise).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              global advance; both stages hold when low
//   ld1, ld2        stage load qualifiers (a valid row is entering S1 / S2)
//   bias_en, act_en, leaky  tile configuration
//   x, b, leak      lane input, lane bias, leak slope (all signed Q-format)
//   y               registered lane result
//   sat             (VPU_STREAM_SAT_EN only) registered "this lane clamped"
module vpu_lane
  import vpu_stream_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ld1,
  input  logic              ld2,
  input  logic              bias_en,
  input  logic              act_en,
  input  logic              leaky,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] leak,
`ifdef VPU_STREAM_SAT_EN
  output logic              sat,
`endif
  output logic [DATA_W-1:0] y
);

  localparam int PW = 2 * DATA_W + 1;

  logic [DATA_W:0]        t_d;
  logic [DATA_W:0]        t_q;
  logic signed [PW-1:0]   t_ext;
  logic signed [PW-1:0]   l_ext;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   act;
  logic [DATA_W-1:0]      y_d;

  // S1 sum: both operands are sign-extended by one bit so the add is exact.
  always_comb begin
    t_d = {x[DATA_W-1], x} + (bias_en ? {b[DATA_W-1], b} : '0);
  end

  // S2 activation: the product is formed at full width and arithmetically
  // shifted, which rounds toward minus infinity for negative results.
  always_comb begin
    t_ext = {{(PW-DATA_W-1){t_q[DATA_W]}}, t_q};
    l_ext = {{(PW-DATA_W){leak[DATA_W-1]}}, leak};
    prod  = t_ext * l_ext;
    if (!act_en || !t_q[DATA_W]) begin
      act = t_ext;
    end else if (!leaky) begin
      act = '0;
    end else begin
      act = prod >>> FRAC_W;
    end
  end

`ifdef VPU_STREAM_SAT_EN
  logic clip_d;

  // Clamp when the bits above the DATA_W sign bit disagree with it.
  always_comb begin
    clip_d = 1'b0;
    y_d    = act[DATA_W-1:0];
    if (act[PW-1:DATA_W-1] != '0 && act[PW-1:DATA_W-1] != '1) begin
      clip_d = 1'b1;
      y_d    = act[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // Clamp flag travels with the S2 result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat <= 1'b0;
    end else if (en && ld2) begin
      sat <= clip_d;
    end
  end
`else
  logic unused_act_hi;

  assign y_d           = act[DATA_W-1:0];
  assign unused_act_hi = &{1'b0, act[PW-1:DATA_W]};
`endif

  // Stage registers only load when a valid row moves in, so a stalled or
  // idle pipeline keeps its last result on y.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q <= '0;
      y   <= '0;
    end else begin
      if (en && ld1) t_q <= t_d;
      if (en && ld2) y   <= y_d;
    end
  end

endmodule

// File: rtl/vpu_stream.sv
// vpu_stream: N-lane streaming vector post-processor (bias add, ReLU /
// leaky-ReLU, fixed-point rescale) between the accumulator drain and the
// unified-buffer write port.
// Optional feature macro: VPU_STREAM_SAT_EN (saturating narrowing + sat_flag).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, num_rows, mode,   tile command; sampled when start is accepted in IDLE
//   leak_factor
//   bias_val/bias_rdy/bias_data  per-tile bias vector handshake (LOAD_BIAS only)
//   in_val/in_rdy/in_data    input row stream
//   out_val/out_rdy/out_data result row stream
//   busy                     controller not in IDLE
//   done                     one-cycle pulse after the last row leaves
//   sat_flag                 (VPU_STREAM_SAT_EN only) some lane clamped this row
module vpu_stream
  import vpu_stream_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int ROW_W   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ROW_W-1:0]          num_rows,
  input  logic [3:0]                mode,
  input  logic [DATA_W-1:0]         leak_factor,
  input  logic                      bias_val,
  output logic                      bias_rdy,
  input  logic [N_LANES*DATA_W-1:0] bias_data,
  input  logic                      in_val,
  output logic                      in_rdy,
  input  logic [N_LANES*DATA_W-1:0] in_data,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [N_LANES*DATA_W-1:0] out_data,
  output logic                      busy,
`ifdef VPU_STREAM_SAT_EN
  output logic                      sat_flag,
`endif
  output logic                      done
);

  vpu_state_e state_q, state_d;

  logic [ROW_W-1:0]          num_rows_q;
  logic [ROW_W-1:0]          in_cnt;
  logic [ROW_W-1:0]          out_cnt;
  logic                      bias_en_q;
  logic                      act_en_q;
  logic                      leaky_q;
  logic [DATA_W-1:0]         leak_q;
  logic [N_LANES*DATA_W-1:0] bias_q;
  logic                      s1_val;
  logic                      advance;
  logic                      in_fire;
  logic                      out_fire;
  logic                      start_acc;
  logic                      last_in;
  logic                      last_out;
  logic                      unused_mode;

  assign unused_mode = mode[3];

  assign start_acc = start && (state_q == IDLE);
  assign advance   = !out_val || out_rdy;
  assign in_rdy    = (state_q == STREAM) && advance && (in_cnt < num_rows_q);
  assign in_fire   = in_val && in_rdy;
  assign out_fire  = out_val && out_rdy;
  assign last_in   = (in_cnt == num_rows_q - ROW_W'(1));
  assign last_out  = (out_cnt == num_rows_q - ROW_W'(1));
  assign busy      = (state_q != IDLE);

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state outputs. The last row is detected on the
  // handshake itself, so the counters never need to reach num_rows+1.
  always_comb begin
    state_d  = state_q;
    bias_rdy = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_rows == '0)              state_d = DONE;
          else if (mode[MODE_BIAS_EN])     state_d = LOAD_BIAS;
          else                             state_d = STREAM;
        end
      end
      LOAD_BIAS: begin
        bias_rdy = 1'b1;
        if (bias_val) state_d = STREAM;
      end
      STREAM: begin
        if (in_fire && last_in) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_fire && last_out) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tile configuration is captured once per accepted start so the
  // upstream controller may change its command inputs mid-tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_rows_q <= '0;
      bias_en_q  <= 1'b0;
      act_en_q   <= 1'b0;
      leaky_q    <= 1'b0;
      leak_q     <= '0;
    end else if (start_acc) begin
      num_rows_q <= num_rows;
      bias_en_q  <= mode[MODE_BIAS_EN];
      act_en_q   <= mode[MODE_ACT_EN];
      leaky_q    <= mode[MODE_LEAKY];
      leak_q     <= leak_factor;
    end
  end

  // Bias vector is only taken while the controller is asking for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bias_q <= '0;
    end else if (state_q == LOAD_BIAS && bias_val) begin
      bias_q <= bias_data;
    end
  end

  // Row counters for the input and output handshakes.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (in_fire)  in_cnt  <= in_cnt + ROW_W'(1);
      if (out_fire) out_cnt <= out_cnt + ROW_W'(1);
    end
  end

  // Stage valids shift together under the single global advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_val  <= 1'b0;
      out_val <= 1'b0;
    end else if (advance) begin
      s1_val  <= in_fire;
      out_val <= s1_val;
    end
  end

`ifdef VPU_STREAM_SAT_EN
  logic [N_LANES-1:0] lane_sat;

  assign sat_flag = out_val && (|lane_sat);
`endif

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    vpu_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (advance),
      .ld1     (in_fire),
      .ld2     (s1_val),
      .bias_en (bias_en_q),
      .act_en  (act_en_q),
      .leaky   (leaky_q),
      .x       (in_data[i*DATA_W +: DATA_W]),
      .b       (bias_q[i*DATA_W +: DATA_W]),
      .leak    (leak_q),
`ifdef VPU_STREAM_SAT_EN
      .sat     (lane_sat[i]),
`endif
      .y       (out_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_vpu_stream.sv
// tb_vpu_stream: directed self-checking bench for vpu_stream with the
// default 4-lane, Q8.8 configuration. Packed rows are written lane3..lane0.
module tb_vpu_stream;

  localparam int N_LANES = 4;
  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int ROW_W   = 10;
  localparam int BUS_W   = N_LANES * DATA_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [ROW_W-1:0] num_rows;
  logic [3:0]       mode;
  logic [DATA_W-1:0] leak_factor;
  logic             bias_val;
  logic             bias_rdy;
  logic [BUS_W-1:0] bias_data;
  logic             in_val;
  logic             in_rdy;
  logic [BUS_W-1:0] in_data;
  logic             out_val;
  logic             out_rdy;
  logic [BUS_W-1:0] out_data;
  logic             busy;
  logic             done;
`ifdef VPU_STREAM_SAT_EN
  logic             sat_flag;
`endif

  int checks   = 0;
  int failures = 0;

  // ReLU tile: bias lane0=+1.0, lane1=-1.0, lane2=+0.5, lane3=0.
  localparam logic [BUS_W-1:0] RELU_BIAS = {16'h0000, 16'h0080, 16'hFF00, 16'h0100};

  logic [BUS_W-1:0] relu_in [8] = '{
    {16'h0000, 16'h0000, 16'h0000, 16'h0000},
    {16'h0010, 16'hFF00, 16'h0200, 16'hFE00},
    {16'h8000, 16'h7F00, 16'h0100, 16'h0000},
    {16'hFFFF, 16'h0001, 16'h0101, 16'hFEFF},
    {16'h1234, 16'h0000, 16'h0000, 16'h0F00},
    {16'h0001, 16'hFF80, 16'h0300, 16'h00FF},
    {16'hFF00, 16'h0040, 16'h7FFF, 16'h8000},
    {16'h0100, 16'h0100, 16'h0100, 16'h0100}
  };

  logic [BUS_W-1:0] relu_exp [8] = '{
    {16'h0000, 16'h0080, 16'h0000, 16'h0100},
    {16'h0010, 16'h0000, 16'h0100, 16'h0000},
    {16'h0000, 16'h7F80, 16'h0000, 16'h0100},
    {16'h0000, 16'h0081, 16'h0001, 16'h0000},
    {16'h1234, 16'h0080, 16'h0000, 16'h1000},
    {16'h0001, 16'h0000, 16'h0200, 16'h01FF},
    {16'h0000, 16'h00C0, 16'h7EFF, 16'h0000},
    {16'h0100, 16'h0180, 16'h0000, 16'h0200}
  };

`ifdef VPU_STREAM_SAT_EN
  localparam logic [BUS_W-1:0] SAT_EXP = {16'h0000, 16'h0000, 16'h8000, 16'h7FFF};
`else
  localparam logic [BUS_W-1:0] SAT_EXP = {16'h0000, 16'h0000, 16'h7F00, 16'h8100};
`endif

  vpu_stream #(
    .N_LANES (N_LANES),
    .DATA_W  (DATA_W),
    .FRAC_W  (FRAC_W),
    .ROW_W   (ROW_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_rows    (num_rows),
    .mode        (mode),
    .leak_factor (leak_factor),
    .bias_val    (bias_val),
    .bias_rdy    (bias_rdy),
    .bias_data   (bias_data),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .in_data     (in_data),
    .out_val     (out_val),
    .out_rdy     (out_rdy),
    .out_data    (out_data),
    .busy        (busy),
`ifdef VPU_STREAM_SAT_EN
    .sat_flag    (sat_flag),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  // Safety net so a hung handshake still ends the run.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [ROW_W-1:0] rows, input logic [3:0] m,
                               input logic [DATA_W-1:0] leak);
    num_rows    = rows;
    mode        = m;
    leak_factor = leak;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic loadBias(input logic [BUS_W-1:0] b);
    checkOutput("bias_rdy_in_load", 64'(bias_rdy), 64'd1);
    bias_val  = 1'b1;
    bias_data = b;
    tick();
    bias_val  = 1'b0;
  endtask

  initial begin
    int ii;
    int oi;
    int done_cnt;
    logic hold_valid;
    logic [BUS_W-1:0] held;
    logic [3:0] rdy_pat;

    rst = 1'b1; start = 1'b0; num_rows = '0; mode = '0; leak_factor = '0;
    bias_val = 1'b0; bias_data = '0; in_val = 1'b0; in_data = '0; out_rdy = 1'b1;
    rdy_pat = 4'b1001;

    // ---- reset state ----
    repeat (2) tick();
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_out_val", 64'(out_val), 64'd0);
    checkOutput("rst_in_rdy", 64'(in_rdy), 64'd0);
    checkOutput("rst_bias_rdy", 64'(bias_rdy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);
    rst = 1'b0;
    tick();

    // ---- single leaky row: bias lane0 +1.0, leak 0.25 ----
    applyStimulus(10'd1, 4'b0111, 16'h0040);
    checkOutput("leaky_busy", 64'(busy), 64'd1);
    loadBias({16'h0000, 16'h0000, 16'h0000, 16'h0100});
    checkOutput("leaky_in_rdy", 64'(in_rdy), 64'd1);
    in_val  = 1'b1;
    in_data = {16'h0000, 16'hFF00, 16'h0200, 16'hFE00};
    tick();
    in_val  = 1'b0;
    checkOutput("leaky_drain_in_rdy", 64'(in_rdy), 64'd0);
    checkOutput("leaky_lat1_out_val", 64'(out_val), 64'd0);
    tick();
    checkOutput("leaky_out_val", 64'(out_val), 64'd1);
    checkOutput("leaky_out_data", out_data, {16'h0000, 16'hFFC0, 16'h0200, 16'hFFC0});
`ifdef VPU_STREAM_SAT_EN
    checkOutput("leaky_sat_flag", 64'(sat_flag), 64'd0);
`endif
    tick();
    checkOutput("leaky_done", 64'(done), 64'd1);
    checkOutput("leaky_out_val_clear", 64'(out_val), 64'd0);
    tick();
    checkOutput("leaky_done_pulse", 64'(done), 64'd0);
    checkOutput("leaky_idle", 64'(busy), 64'd0);

    // ---- ReLU, 8 rows back-to-back with out_rdy held high ----
    applyStimulus(10'd8, 4'b0011, 16'h0000);
    loadBias(RELU_BIAS);
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        in_val  = 1'b1;
        in_data = relu_in[c];
        checkOutput("relu_in_rdy", 64'(in_rdy), 64'd1);
      end else begin
        in_val = 1'b0;
        checkOutput("relu_drain_in_rdy", 64'(in_rdy), 64'd0);
      end
      if (c >= 2) begin
        checkOutput("relu_out_val", 64'(out_val), 64'd1);
        checkOutput("relu_out_data", out_data, relu_exp[c-2]);
      end else begin
        checkOutput("relu_fill_out_val", 64'(out_val), 64'd0);
      end
      checkOutput("relu_no_early_done", 64'(done), 64'd0);
      tick();
    end
    checkOutput("relu_done", 64'(done), 64'd1);
    tick();
    checkOutput("relu_done_pulse", 64'(done), 64'd0);
    checkOutput("relu_idle", 64'(busy), 64'd0);

    // ---- same stream with out_rdy pattern 1,0,0,1 ----
    applyStimulus(10'd8, 4'b0011, 16'h0000);
    loadBias(RELU_BIAS);
    ii = 0; oi = 0; done_cnt = 0; hold_valid = 1'b0; held = '0;
    for (int c = 0; c < 80 && done_cnt == 0; c++) begin
      out_rdy = rdy_pat[c % 4];
      in_val  = (ii < 8);
      in_data = relu_in[(ii < 8) ? ii : 7];
      #1;
      if (hold_valid) checkOutput("bp_stall_stable", out_data, held);
      if (out_val && !out_rdy) begin
        checkOutput("bp_stall_in_rdy", 64'(in_rdy), 64'd0);
        held       = out_data;
        hold_valid = 1'b1;
      end else begin
        hold_valid = 1'b0;
      end
      if (out_val && out_rdy) begin
        if (oi < 8) checkOutput("bp_row_data", out_data, relu_exp[oi]);
        oi++;
      end
      if (done) done_cnt++;
      if (in_val && in_rdy) ii++;
      tick();
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    checkOutput("bp_rows_in", 64'(ii), 64'd8);
    checkOutput("bp_rows_out", 64'(oi), 64'd8);
    checkOutput("bp_done_seen", 64'(done_cnt), 64'd1);
    tick();
    checkOutput("bp_idle", 64'(busy), 64'd0);

    // ---- empty tile, then start while busy ----
    applyStimulus(10'd0, 4'b0001, 16'h0000);
    checkOutput("zero_busy", 64'(busy), 64'd1);
    checkOutput("zero_done", 64'(done), 64'd1);
    checkOutput("zero_bias_rdy", 64'(bias_rdy), 64'd0);
    tick();
    checkOutput("zero_idle", 64'(busy), 64'd0);
    checkOutput("zero_done_pulse", 64'(done), 64'd0);

    applyStimulus(10'd1, 4'b0000, 16'h0000);
    applyStimulus(10'd5, 4'b0001, 16'h0000);
    checkOutput("ignored_start_busy", 64'(busy), 64'd1);
    checkOutput("ignored_start_bias_rdy", 64'(bias_rdy), 64'd0);
    checkOutput("ignored_start_in_rdy", 64'(in_rdy), 64'd1);
    in_val  = 1'b1;
    in_data = {16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF};
    tick();
    in_val  = 1'b0;
    checkOutput("ignored_start_one_row", 64'(in_rdy), 64'd0);
    tick();
    checkOutput("passthru_out_data", out_data, {16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF});
    tick();
    checkOutput("passthru_done", 64'(done), 64'd1);
    tick();

    // ---- reset mid-STREAM with two rows in flight ----
    applyStimulus(10'd6, 4'b0010, 16'h0000);
    in_val  = 1'b1;
    in_data = relu_in[1];
    tick();
    in_data = relu_in[2];
    tick();
    rst    = 1'b1;
    in_val = 1'b0;
    tick();
    rst    = 1'b0;
    checkOutput("abort_out_val", 64'(out_val), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_in_rdy", 64'(in_rdy), 64'd0);
    checkOutput("abort_out_data", out_data, 64'd0);
    tick();
    checkOutput("abort_no_late_out", 64'(out_val), 64'd0);
    applyStimulus(10'd1, 4'b0000, 16'h0000);
    in_val  = 1'b1;
    in_data = {16'h0042, 16'hFFFE, 16'h0100, 16'hC000};
    tick();
    in_val  = 1'b0;
    tick();
    checkOutput("clean_out_val", 64'(out_val), 64'd1);
    checkOutput("clean_out_data", out_data, {16'h0042, 16'hFFFE, 16'h0100, 16'hC000});
    tick();
    checkOutput("clean_done", 64'(done), 64'd1);
    tick();

    // ---- narrowing: overflow on lane0 (+), lane1 (-) ----
    applyStimulus(10'd1, 4'b0001, 16'h0000);
    loadBias({16'h0000, 16'h0000, 16'hFF00, 16'h0200});
    in_val  = 1'b1;
    in_data = {16'h0000, 16'h0000, 16'h8000, 16'h7F00};
    tick();
    in_val  = 1'b0;
    tick();
    checkOutput("narrow_out_val", 64'(out_val), 64'd1);
    checkOutput("narrow_out_data", out_data, SAT_EXP);
`ifdef VPU_STREAM_SAT_EN
    checkOutput("narrow_sat_flag", 64'(sat_flag), 64'd1);
`endif
    tick();
    checkOutput("narrow_done", 64'(done), 64'd1);
    tick();
    checkOutput("final_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
